// File: rtl/sample_issuer.sv
// sample_issuer: accepts upstream samples, issues them to the FIR core,
// and requests a fresh coefficient set after every block of samples.
`timescale 1ns/1ps
module sample_issuer #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 1000,
  parameter int CNT_BITS   = 10
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  input  logic                  filt_busy,
  output logic                  filt_start,
  output logic [DATA_WIDTH-1:0] filt_sample,
  output logic                  cnt_up,
  output logic                  clear,
  output logic                  coeff_req,
  input  logic                  coeff_done,
  output logic                  block_done,
  output logic [CNT_BITS-1:0]   sample_count
);

  localparam logic [CNT_BITS-1:0] LP_BLK =
    CNT_BITS'(BLOCK_SIZE);

  typedef enum logic [2:0] {
    S_COEFF,
    S_CLEAR,
    S_ACCEPT,
    S_ISSUE,
    S_WAIT,
    S_END
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sample;
  logic [CNT_BITS-1:0]   r_count;
  logic                  w_hs;

  assign src_ready = (r_state == S_ACCEPT) && !filt_busy;
  assign w_hs      = src_valid && src_ready;

  // Pulses and levels decode directly from the state register.
  assign coeff_req    = (r_state == S_COEFF);
  assign clear        = (r_state == S_CLEAR);
  assign filt_start   = (r_state == S_ISSUE);
  assign cnt_up       = (r_state == S_ISSUE);
  assign block_done   = (r_state == S_END);
  assign filt_sample  = r_sample;
  assign sample_count = r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_COEFF;
      r_sample <= '0;
      r_count  <= '0;
    end else begin
      unique case (r_state)
        S_COEFF: begin
          if (coeff_done) r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          r_count <= '0;
          r_state <= S_ACCEPT;
        end
        S_ACCEPT: begin
          if (w_hs) begin
            r_sample <= src_data;
            r_count  <= r_count + CNT_BITS'(1);
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!filt_busy) begin
            r_state <= (r_count == LP_BLK) ? S_END : S_ACCEPT;
          end
        end
        S_END: begin
          r_state <= S_COEFF;
        end
        default: begin
          r_state <= S_COEFF;
        end
      endcase
    end
  end

endmodule
